// File: rtl/pc_stack.sv
// Program-counter stage: holds the instruction address, selects the next PC from
// the decoder strobes and keeps subroutine return addresses in a small LIFO.
module pc_stack #(
  parameter int p_size      = 6,
  parameter int stack_depth = 4
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               Stall,
  input  logic                               Jump,
  input  logic                               Rel,
  input  logic                               Call,
  input  logic                               Ret,
  input  logic [p_size-1:0]                  Target,
  output logic [p_size-1:0]                  address,
  output logic [$clog2(stack_depth+1)-1:0]   Depth,
  output logic                               Overflow,
  output logic                               Underflow
);
  localparam int DW = $clog2(stack_depth + 1);
  localparam int AW = (stack_depth > 1) ? $clog2(stack_depth) : 1;

  // All PC sums are p_size wide and drop the carry; the offset is two's complement.
  function automatic logic [p_size-1:0] wrap_add(input logic [p_size-1:0]        base,
                                                 input logic signed [p_size-1:0] offset);
    logic [p_size:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    return sum[p_size-1:0];
  endfunction

  logic [p_size-1:0] stack_mem [stack_depth];

  logic [p_size-1:0] pc_p0;
  logic [DW-1:0]     depth_p0;
  logic              ovf_p0;
  logic              unf_p0;

  logic [p_size-1:0] pc_inc;
  logic [p_size-1:0] pc_nxt;
  logic [DW-1:0]     depth_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     push_idx;

  assign pc_inc   = wrap_add(pc_p0, p_size'(1));
  assign top_idx  = AW'(depth_p0 - 1'b1);
  assign push_idx = AW'(depth_p0);

  always_comb begin
    pc_nxt    = pc_p0;
    depth_nxt = depth_p0;
    ovf_nxt   = ovf_p0;
    unf_nxt   = unf_p0;
    push      = 1'b0;
    if (!Stall) begin
      if (Ret) begin
        if (depth_p0 != '0) begin
          pc_nxt    = stack_mem[top_idx];
          depth_nxt = depth_p0 - 1'b1;
        end else begin
          unf_nxt = 1'b1;
          pc_nxt  = pc_inc;
        end
      end else if (Call) begin
        // The jump is taken even when the push has to be dropped.
        pc_nxt = Target;
        if (depth_p0 < DW'(stack_depth)) begin
          push      = 1'b1;
          depth_nxt = depth_p0 + 1'b1;
        end else begin
          ovf_nxt = 1'b1;
        end
      end else if (Jump) begin
        pc_nxt = Target;
      end else if (Rel) begin
        pc_nxt = wrap_add(pc_p0, Target);
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  // Stage p0: PC, stack pointer and sticky flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_p0    <= '0;
      depth_p0 <= '0;
      ovf_p0   <= 1'b0;
      unf_p0   <= 1'b0;
    end else begin
      pc_p0    <= pc_nxt;
      depth_p0 <= depth_nxt;
      ovf_p0   <= ovf_nxt;
      unf_p0   <= unf_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) stack_mem[push_idx] <= pc_inc;
  end

  assign address   = pc_p0;
  assign Depth     = depth_p0;
  assign Overflow  = ovf_p0;
  assign Underflow = unf_p0;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: sequential counting, call/return, stack overflow and
// underflow, relative branches, stall, strobe priority and asynchronous reset.
module tb_pc_stack;
  localparam int P = 6;
  localparam int SD = 4;

  logic         Clock;
  logic         Reset;
  logic         Stall;
  logic         Jump;
  logic         Rel;
  logic         Call;
  logic         Ret;
  logic [P-1:0] Target;
  logic [P-1:0] address;
  logic [2:0]   Depth;
  logic         Overflow;
  logic         Underflow;

  int checks   = 0;
  int failures = 0;

  pc_stack #(.p_size(P), .stack_depth(SD)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Jump(Jump), .Rel(Rel),
    .Call(Call), .Ret(Ret), .Target(Target), .address(address), .Depth(Depth),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Stall = 0; Jump = 0; Rel = 0; Call = 0; Ret = 0; Target = '0;
  endtask

  task automatic do_jump(input logic [P-1:0] t);
    idle(); Jump = 1; Target = t; step(); idle();
  endtask

  task automatic do_call(input logic [P-1:0] t);
    idle(); Call = 1; Target = t; step(); idle();
  endtask

  task automatic do_ret();
    idle(); Ret = 1; step(); idle();
  endtask

  initial begin
    idle();
    Reset = 1;
    #1;
    check("rst_addr", 32'(address), 0);
    check("rst_depth", 32'(Depth), 0);
    check("rst_ovf", 32'(Overflow), 0);
    check("rst_unf", 32'(Underflow), 0);
    #1 Reset = 0;

    for (int k = 1; k <= 70; k++) begin
      step();
      check("count", 32'(address), 32'(k % 64));
    end
    check("count_depth", 32'(Depth), 0);

    // Call from PC 5 to 20, three idle cycles, then return to 6
    do_jump(4);
    step();
    check("pre_call_pc", 32'(address), 5);
    do_call(20);
    check("call_pc", 32'(address), 20);
    check("call_depth", 32'(Depth), 1);
    for (int k = 21; k <= 23; k++) begin
      step();
      check("sub_pc", 32'(address), 32'(k));
    end
    do_ret();
    check("ret_pc", 32'(address), 6);
    check("ret_depth", 32'(Depth), 0);

    // Five nested calls into a four-entry stack
    do_jump(1);
    do_call(10); check("n1_pc", 32'(address), 10);
    do_call(20); check("n2_pc", 32'(address), 20);
    do_call(30); check("n3_pc", 32'(address), 30);
    do_call(40); check("n4_pc", 32'(address), 40);
    check("n4_depth", 32'(Depth), 4);
    check("n4_ovf", 32'(Overflow), 0);
    do_call(50);
    check("n5_pc", 32'(address), 50);
    check("n5_depth", 32'(Depth), 4);
    check("n5_ovf", 32'(Overflow), 1);
    do_ret(); check("r1_pc", 32'(address), 31);
    do_ret(); check("r2_pc", 32'(address), 21);
    do_ret(); check("r3_pc", 32'(address), 11);
    do_ret(); check("r4_pc", 32'(address), 2);
    check("r4_depth", 32'(Depth), 0);
    check("r4_unf", 32'(Underflow), 0);
    do_ret();
    check("r5_pc", 32'(address), 3);
    check("r5_unf", 32'(Underflow), 1);
    check("r5_depth", 32'(Depth), 0);
    check("ovf_sticky", 32'(Overflow), 1);

    // Relative branches wrap modulo 64
    do_jump(1);
    idle(); Rel = 1; Target = 6'h3E; step(); idle();
    check("rel_neg", 32'(address), 63);
    idle(); Rel = 1; Target = 6'h02; step(); idle();
    check("rel_wrap", 32'(address), 1);

    // Stall overrides a pending jump
    do_jump(4);
    Stall = 1; Jump = 1; Target = 9;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", 32'(address), 4);
    end
    Stall = 0;
    step();
    check("unstall_pc", 32'(address), 9);
    idle();

    // Ret wins over Call and Jump
    do_call(30);
    check("prio_call_pc", 32'(address), 30);
    idle(); Call = 1; Ret = 1; Jump = 1; Target = 40; step(); idle();
    check("prio_pc", 32'(address), 10);
    check("prio_depth", 32'(Depth), 0);

    // Reach PC 12 with two entries stacked, then reset between edges
    do_call(5);
    do_call(11);
    step();
    check("pre_rst_pc", 32'(address), 12);
    check("pre_rst_depth", 32'(Depth), 2);
    check("pre_rst_ovf", 32'(Overflow), 1);
    #2 Reset = 1;
    #1;
    check("arst_addr", 32'(address), 0);
    check("arst_depth", 32'(Depth), 0);
    check("arst_ovf", 32'(Overflow), 0);
    check("arst_unf", 32'(Underflow), 0);
    #1 Reset = 0;
    step(); check("resume1", 32'(address), 1);
    step(); check("resume2", 32'(address), 2);

    // Pushed return address wraps from 63 to 0
    do_jump(63);
    do_call(7);
    check("wrap_call_pc", 32'(address), 7);
    do_ret();
    check("wrap_ret_pc", 32'(address), 0);
    check("wrap_ret_depth", 32'(Depth), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
